// File: rtl/img_phase_sequencer.sv
// img_phase_sequencer: shared image SRAM owner, RX -> CONV -> TX flow.
// Define IMG_SEQ_CONV_EN to include the CONV phase; otherwise RX -> TX.
package img_sram_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } img_sram_ctrl_t;

endpackage

module img_phase_sequencer
  import img_sram_pkg::*;
#(
  parameter int GAP_CYCLES    = 1,
  parameter int START_TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           start,
  input  logic           rx_busy,
  input  logic           cv_busy,
  input  logic           tx_busy,
  input  img_sram_ctrl_t rx_sram_ctrl,
  input  img_sram_ctrl_t cv_sram_ctrl,
  input  img_sram_ctrl_t tx_sram_ctrl,
  output logic           rx_en,
  output logic           cv_en,
  output logic           tx_en,
  output img_sram_ctrl_t sram_ctrl,
  output logic [1:0]     owner,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [TW-1:0] T_ONE   = TW'(1);
  localparam logic [TW-1:0] TO_LAST = TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0] TO_HIT  = TW'(START_TIMEOUT);
  localparam logic [GW-1:0] G_ONE   = GW'(1);
  localparam logic [GW-1:0] G_LAST  = GW'(GAP_CYCLES - 1);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_RX   = 2'd1;
  localparam logic [1:0] OWN_CV   = 2'd2;
  localparam logic [1:0] OWN_TX   = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RX_START,
    S_RX_WAIT,
    S_GAP,
`ifdef IMG_SEQ_CONV_EN
    S_CV_START,
    S_CV_WAIT,
`endif
    S_TX_START,
    S_TX_WAIT,
    S_DONE
  } state_t;

`ifdef IMG_SEQ_CONV_EN
  localparam state_t AFTER_RX = S_CV_START;
`else
  localparam state_t AFTER_RX = S_TX_START;
`endif

  state_t          state_q, state_d;
  state_t          nxt_q, nxt_d;
  state_t          w_state;
  logic [1:0]      owner_q, owner_d;
  logic            seen_q, seen_d;
  logic            err_q, err_d;
  logic            w_err;
  logic [TW-1:0]   tcnt_q, tcnt_d, w_tcnt;
  logic [GW-1:0]   gcnt_q, gcnt_d;
  logic            cur_busy;
  logic            seen_eff;

  // busy of the current owner only; everyone else is ignored
  always_comb begin
    cur_busy = 1'b0;
    case (owner_q)
      OWN_RX:  cur_busy = rx_busy;
`ifdef IMG_SEQ_CONV_EN
      OWN_CV:  cur_busy = cv_busy;
`endif
      OWN_TX:  cur_busy = tx_busy;
      default: cur_busy = 1'b0;
    endcase
  end

  assign seen_eff = seen_q | cur_busy;

  // shared X_WAIT outcome: timeout, completion, or keep counting
  always_comb begin
    w_state = state_q;
    w_tcnt  = tcnt_q;
    w_err   = err_q;
    if (tcnt_q == TO_HIT) begin
      w_state = S_IDLE;
    end else if (seen_q && !cur_busy) begin
      w_state = (owner_q == OWN_TX) ? S_DONE : S_GAP;
    end else if (!seen_eff) begin
      w_tcnt = tcnt_q + T_ONE;
      if (tcnt_q == TO_LAST) w_err = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    nxt_d   = nxt_q;
    seen_d  = seen_q;
    err_d   = err_q;
    tcnt_d  = tcnt_q;
    gcnt_d  = gcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d   = 1'b0;
          state_d = S_RX_START;
        end
      end
      S_RX_START: begin
        seen_d  = cur_busy;
        tcnt_d  = '0;
        state_d = S_RX_WAIT;
      end
      S_RX_WAIT: begin
        seen_d  = seen_eff;
        tcnt_d  = w_tcnt;
        err_d   = w_err;
        gcnt_d  = '0;
        nxt_d   = AFTER_RX;
        state_d = w_state;
      end
`ifdef IMG_SEQ_CONV_EN
      S_CV_START: begin
        seen_d  = cur_busy;
        tcnt_d  = '0;
        state_d = S_CV_WAIT;
      end
      S_CV_WAIT: begin
        seen_d  = seen_eff;
        tcnt_d  = w_tcnt;
        err_d   = w_err;
        gcnt_d  = '0;
        nxt_d   = S_TX_START;
        state_d = w_state;
      end
`endif
      S_GAP: begin
        if (gcnt_q == G_LAST) begin
          state_d = nxt_q;
        end else begin
          gcnt_d = gcnt_q + G_ONE;
        end
      end
      S_TX_START: begin
        seen_d  = cur_busy;
        tcnt_d  = '0;
        state_d = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        seen_d  = seen_eff;
        tcnt_d  = w_tcnt;
        err_d   = w_err;
        state_d = w_state;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    owner_d = OWN_NONE;
    unique case (state_d)
      S_RX_START, S_RX_WAIT: owner_d = OWN_RX;
`ifdef IMG_SEQ_CONV_EN
      S_CV_START, S_CV_WAIT: owner_d = OWN_CV;
`endif
      S_TX_START, S_TX_WAIT: owner_d = OWN_TX;
      default:               owner_d = OWN_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      nxt_q   <= S_IDLE;
      owner_q <= OWN_NONE;
      seen_q  <= 1'b0;
      err_q   <= 1'b0;
      tcnt_q  <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      nxt_q   <= nxt_d;
      owner_q <= owner_d;
      seen_q  <= seen_d;
      err_q   <= err_d;
      tcnt_q  <= tcnt_d;
      gcnt_q  <= gcnt_d;
    end
  end

  // owner 0 yields the all-zero idle command
  always_comb begin
    sram_ctrl = '0;
    case (owner_q)
      OWN_RX:  sram_ctrl = rx_sram_ctrl;
`ifdef IMG_SEQ_CONV_EN
      OWN_CV:  sram_ctrl = cv_sram_ctrl;
`endif
      OWN_TX:  sram_ctrl = tx_sram_ctrl;
      default: sram_ctrl = '0;
    endcase
  end

  assign rx_en = (state_q == S_RX_START);
  assign tx_en = (state_q == S_TX_START);
`ifdef IMG_SEQ_CONV_EN
  assign cv_en = (state_q == S_CV_START);
`else
  assign cv_en = 1'b0;
  logic unused_cv;
  assign unused_cv = ^{cv_busy, cv_sram_ctrl};
`endif
  assign owner = owner_q;
  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_DONE);
  assign err   = err_q;

endmodule

// File: tb/tb_img_phase_sequencer.sv
// tb_img_phase_sequencer: timeline-model bench for img_phase_sequencer.
// Builds per-cycle expectations from phase durations, then checks each cycle.
module tb_img_phase_sequencer;
  import img_sram_pkg::*;

  localparam int GAP = 1;
  localparam int TO  = 16;
  localparam int N   = 1024;
`ifdef IMG_SEQ_CONV_EN
  localparam int NPH = 3;
`else
  localparam int NPH = 2;
`endif

  logic           clk;
  logic           rstn;
  logic           start;
  logic           rx_busy, cv_busy, tx_busy;
  img_sram_ctrl_t rx_sram_ctrl, cv_sram_ctrl, tx_sram_ctrl;
  logic           rx_en, cv_en, tx_en;
  img_sram_ctrl_t sram_ctrl;
  logic [1:0]     owner;
  logic           busy, done, err;

  img_phase_sequencer #(
    .GAP_CYCLES   (GAP),
    .START_TIMEOUT(TO)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .rx_busy     (rx_busy),
    .cv_busy     (cv_busy),
    .tx_busy     (tx_busy),
    .rx_sram_ctrl(rx_sram_ctrl),
    .cv_sram_ctrl(cv_sram_ctrl),
    .tx_sram_ctrl(tx_sram_ctrl),
    .rx_en       (rx_en),
    .cv_en       (cv_en),
    .tx_en       (tx_en),
    .sram_ctrl   (sram_ctrl),
    .owner       (owner),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       st    [N];
  logic       bsy   [4][N];
  logic [1:0] e_own [N];
  logic       e_en  [4][N];
  logic       e_done[N];
  logic       e_bz  [N];
  logic       e_err [N];

  int cyc;
  int n_cmp;
  int n_err;
  int tx_mid;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, expv);
    end
  endtask

  function automatic int ph_of(input int i);
`ifdef IMG_SEQ_CONV_EN
    return i + 1;
`else
    return (i == 0) ? 1 : 3;
`endif
  endfunction

  function automatic img_sram_ctrl_t rnd_ctrl();
    img_sram_ctrl_t c;
    c.req   = 1'b1;
    c.we    = 1'($urandom_range(0, 1));
    c.addr  = 6'($urandom);
    c.wdata = $urandom;
    c.be    = 4'($urandom);
    return c;
  endfunction

  task automatic noise(input int ph, input int c);
    for (int q = 1; q <= 3; q++)
      if (q != ph) bsy[q][c] = 1'($urandom_range(0, 1));
  endtask

  // stuck < 0: no stuck phase; fd > 0 fixes latency fl and busy length fd
  task automatic plan_flow(input int s0, input int stuck, input int fl,
                           input int fd, output int idle_at);
    int t, k, ph, l, d;
    st[s0] = 1'b1;
    for (int c = s0 + 1; c < N; c++) e_err[c] = 1'b0;
    t = s0 + 1;
    idle_at = t;
    for (int i = 0; i < NPH; i++) begin
      ph = ph_of(i);
      l  = (fd > 0) ? fl : int'($urandom_range(0, 3));
      d  = (fd > 0) ? fd : int'($urandom_range(1, 12));
      e_en[ph][t] = 1'b1;
      if (i == stuck) begin
        k = t + TO + 1;
        for (int c = t; c <= k; c++) begin
          e_own[c] = 2'(ph);
          e_bz[c]  = 1'b1;
          noise(ph, c);
        end
        for (int c = k; c < N; c++) e_err[c] = 1'b1;
        idle_at = k + 1;
        return;
      end
      k = t + l + d;
      for (int c = t; c <= k; c++) begin
        e_own[c] = 2'(ph);
        e_bz[c]  = 1'b1;
        noise(ph, c);
      end
      for (int c = t + l; c < k; c++) bsy[ph][c] = 1'b1;
      if (ph == 3) begin
        tx_mid = t + 1 + (l + d - 1) / 2;
        e_done[k + 1] = 1'b1;
        e_bz[k + 1]   = 1'b1;
        idle_at = k + 2;
      end else begin
        for (int c = k + 1; c <= k + GAP; c++) e_bz[c] = 1'b1;
        t = k + 1 + GAP;
      end
    end
  endtask

  task automatic clear_from(input int c0);
    for (int c = c0; c < N; c++) begin
      st[c]     = 1'b0;
      e_own[c]  = 2'd0;
      e_done[c] = 1'b0;
      e_bz[c]   = 1'b0;
      e_err[c]  = 1'b0;
      for (int q = 0; q < 4; q++) e_en[q][c] = 1'b0;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_owner"}, 64'(owner), 64'd0);
    chk({tag, "_en"}, 64'({rx_en, cv_en, tx_en}), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_ctrl"}, 64'(sram_ctrl), 64'd0);
  endtask

  task automatic drive_check();
    img_sram_ctrl_t ex;
    start        = st[cyc];
    rx_busy      = bsy[1][cyc];
    cv_busy      = bsy[2][cyc];
    tx_busy      = bsy[3][cyc];
    rx_sram_ctrl = rnd_ctrl();
    cv_sram_ctrl = rnd_ctrl();
    tx_sram_ctrl = rnd_ctrl();
    #1;
    case (e_own[cyc])
      2'd1:    ex = rx_sram_ctrl;
      2'd2:    ex = cv_sram_ctrl;
      2'd3:    ex = tx_sram_ctrl;
      default: ex = '0;
    endcase
    chk("owner", 64'(owner), 64'(e_own[cyc]));
    chk("rx_en", 64'(rx_en), 64'(e_en[1][cyc]));
    chk("cv_en", 64'(cv_en), 64'(e_en[2][cyc]));
    chk("tx_en", 64'(tx_en), 64'(e_en[3][cyc]));
    chk("done", 64'(done), 64'(e_done[cyc]));
    chk("busy", 64'(busy), 64'(e_bz[cyc]));
    chk("err", 64'(err), 64'(e_err[cyc]));
    chk("sram_ctrl", 64'(sram_ctrl), 64'(ex));
  endtask

  task automatic run_to(input int cend);
    while (cyc < cend) begin
      @(negedge clk);
      cyc++;
      drive_check();
    end
  endtask

  initial begin
    int ia, ia2, s, r;
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    tx_mid = 0;
    clear_from(0);
    for (int c = 0; c < N; c++)
      for (int q = 0; q < 4; q++) bsy[q][c] = 1'b0;
    rstn  = 1'b0;
    start = 1'b0;
    rx_busy = 1'b0;
    cv_busy = 1'b0;
    tx_busy = 1'b0;
    rx_sram_ctrl = rnd_ctrl();
    cv_sram_ctrl = rnd_ctrl();
    tx_sram_ctrl = rnd_ctrl();
    #1;
    chk_reset("por");
    #1;
    rstn = 1'b1;
    drive_check();

    // nominal flow: busy one cycle after en, ten cycles long
    plan_flow(2, -1, 1, 10, ia);
    run_to(ia + 2);

    // randomized busy latency and length
    for (int n = 0; n < 3; n++) begin
      s = cyc + int'($urandom_range(1, 3));
      plan_flow(s, -1, 0, 0, ia);
      run_to(ia + 1);
    end

    // second phase never raises busy, then a clean flow clears err
    s = cyc + 2;
    plan_flow(s, 1, 0, 0, ia);
    run_to(ia + 3);
    s = cyc + 1;
    plan_flow(s, -1, 0, 0, ia);
    run_to(ia + 1);

    // start held high across two flows, released after the second DONE
    s = cyc + 2;
    plan_flow(s, -1, 0, 0, ia);
    plan_flow(ia, -1, 0, 0, ia2);
    for (int c = s; c <= ia2 - 1; c++) st[c] = 1'b1;
    run_to(ia2 + 3);

    // short reset pulse during TX_WAIT, then a fresh flow
    s = cyc + 2;
    plan_flow(s, -1, 0, 0, ia);
    r = tx_mid;
    run_to(r);
    rstn = 1'b0;
    #1;
    chk_reset("mid_rst");
    rstn = 1'b1;
    clear_from(r + 1);
    run_to(ia + 1);
    s = cyc + 1;
    plan_flow(s, -1, 0, 0, ia);
    run_to(ia + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/img_phase_sequencer.md
# img_phase_sequencer

Top-level scheduler for the single shared image SRAM (`img_sram_4_64`). On a `start` request it runs the image flow RX → CONV → TX. For each phase it grants SRAM ownership to one requester, pulses that requester's `en`, and tracks its `busy`. It replaces ad-hoc muxing of `img_sram_ctrl_t` buses and inserts idle gap cycles at every ownership hand-over.

## Interface
Parameters:
- `GAP_CYCLES`, 1: idle-command cycles between phases (≥1).
- `START_TIMEOUT`, 16: cycles allowed for a requester's `busy` to rise after its `en` pulse (≥2).

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin one full flow; sampled only in IDLE.
- `rx_busy`, `cv_busy`, `tx_busy`  in  1 each  busy from io_rx_controller, convolution engine, io_tx_controller.
- `rx_sram_ctrl`, `cv_sram_ctrl`, `tx_sram_ctrl`  in  `img_sram_ctrl_t`  requester SRAM commands.
- `rx_en`, `cv_en`, `tx_en`  out  1 each  one-cycle start pulses.
- `sram_ctrl`  out  `img_sram_ctrl_t`  command to SRAM.
- `owner`  out  2  0=none, 1=RX, 2=CONV, 3=TX.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse on flow completion.
- `err`  out  1  sticky timeout flag; cleared by next accepted `start`.

## Operation
- States: IDLE, RX_START, RX_WAIT, GAP, CV_START, CV_WAIT, TX_START, TX_WAIT, DONE.
- IDLE: `start`=1 clears `err` and moves to RX_START.
- X_START (X ∈ RX/CV/TX):
  - `owner`=X and `X_en`=1 for exactly this cycle.
  - Clears the seen flag and the timeout counter.
  - Goes to X_WAIT.
- X_WAIT:
  - `owner`=X.
  - Sets the seen flag when `X_busy`=1. `X_busy` sampled in X_START also counts.
  - seen && !`X_busy` → GAP (after RX, CONV) or DONE (after TX).
  - !seen and counter reaches `START_TIMEOUT` → set `err`, go to IDLE (no `done`).
- GAP:
  - `owner`=0.
  - Counts `GAP_CYCLES`, then goes to the next phase's X_START.
- DONE: `done`=1 for one cycle, then IDLE.
- `sram_ctrl` mux, combinational from registered `owner`:
  - Forwards the owner's ctrl bus.
  - `owner`=0 drives `'0`, which is the SRAM idle (no access) command.
- Non-owner ctrl buses are ignored, even if active.
- `start` outside IDLE is ignored; it is not queued.
- `busy` of a non-current requester is ignored.

## Timing
- Reset values: state=IDLE, `owner`=0, `sram_ctrl`='0, all `*_en`=0, `busy`=0, `done`=0, `err`=0, counters=0.
- Asynchronous reset mid-flow immediately returns all outputs to reset values. No partial phase resumes after reset.
- Latency: `start` sampled at edge 0 → RX_START in cycle 1.
- Phase completion: `X_busy` low in cycle k with seen=1 → GAP begins at cycle k+1, and the next X_START begins at cycle k+1+`GAP_CYCLES`. After TX, DONE is at cycle k+1.
- Ownership: `owner` switches only on state transitions, never within a phase. At least `GAP_CYCLES` idle commands separate two owners.
- `busy` never rises (stuck low): `err` asserts on the cycle the counter hits `START_TIMEOUT`; `owner` returns to 0 the next cycle.
- `busy` never falls (stuck high): wait forever. There is no completion timeout.
- Simultaneous `start` and DONE: `start` is ignored. A new flow needs `start` while in IDLE.

## Configuration
- `IMG_SEQ_CONV_EN` defined:
  - Full RX → GAP → CONV → GAP → TX flow.
- Undefined:
  - CV_START and CV_WAIT are removed; RX → GAP → TX.
  - `cv_en` is tied 0; `cv_busy` and `cv_sram_ctrl` are unused.
  - `owner` never equals 2.

## Test plan
Stubs raise busy the cycle after `en` and hold it 10 cycles; `start` is sampled at edge 0; GAP_CYCLES=1.
- Nominal, conv enabled → `rx_en` in cycle 1, `cv_en` in cycle 14, `tx_en` in cycle 27, `done` in cycle 39, `owner` sequence 1,0,2,0,3,0.
- Nominal, `IMG_SEQ_CONV_EN` undefined → `rx_en` in cycle 1, `tx_en` in cycle 14, `done` in cycle 26, `cv_en` never high.
- CONV stub never raises busy, START_TIMEOUT=16 → `err`=1, no `done`, state IDLE. A following `start` clears `err` and runs nominal.
- Non-owner ctrl buses driven active throughout → `sram_ctrl` always equals the owner's bus, or '0 during GAP/IDLE/DONE.
- `rstn` pulled low for 1 ns during TX_WAIT → all outputs immediately at reset values. A new `start` runs the full flow from RX.
- `start` held high continuously → flows run back-to-back; each `done` is followed by IDLE, then RX_START two cycles after DONE.
